// File: rtl/fetch_sequencer.sv
// Instruction fetch sequencer: owns the PC, drives the combinational instruction
// memory and registers the IF/ID stage with stall, branch-flush and halt handling.
module fetch_sequencer #(
    parameter int unsigned                  ADDR_WIDTH  = 8,
    parameter int unsigned                  INSTR_WIDTH = 32,
    parameter logic [ADDR_WIDTH-1:0]        RESET_PC    = '0,
    parameter logic [INSTR_WIDTH-1:0]       HALT_OPCODE = '1
) (
    input  logic                   Clk,
    input  logic                   Reset_n,
    output logic [ADDR_WIDTH-1:0]  Address,
    input  logic [INSTR_WIDTH-1:0] InstructionIn,
    input  logic                   Stall,
    input  logic                   BranchTaken,
    input  logic [ADDR_WIDTH-1:0]  BranchTarget,
    output logic [INSTR_WIDTH-1:0] InstructionOut,
    output logic [ADDR_WIDTH-1:0]  PCOut,
    output logic                   Valid,
    output logic                   Halted,
    output logic [15:0]            FetchCount
);

    typedef enum logic [1:0] {
        BOOT,
        RUN,
        HALT
    } state_t;

    state_t                  state;
    logic [ADDR_WIDTH-1:0]   pc;

    assign Address = pc;

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state          <= BOOT;
            pc             <= RESET_PC;
            InstructionOut <= '0;
            PCOut          <= '0;
            Valid          <= 1'b0;
            Halted         <= 1'b0;
            FetchCount     <= '0;
        end else if (BranchTaken) begin
            // Redirect flushes IF/ID but keeps PCOut of the last real fetch.
            pc             <= BranchTarget;
            InstructionOut <= '0;
            Valid          <= 1'b0;
            Halted         <= 1'b0;
            state          <= RUN;
        end else if (!Stall) begin
            case (state)
                BOOT: state <= RUN;
                RUN: begin
                    InstructionOut <= InstructionIn;
                    PCOut          <= pc;
                    Valid          <= 1'b1;
                    if (FetchCount != '1) begin
                        FetchCount <= FetchCount + 16'd1;
                    end
                    // The halt word is delivered to decode, but the PC parks on it.
                    if (InstructionIn == HALT_OPCODE) begin
                        state  <= HALT;
                        Halted <= 1'b1;
                    end else begin
                        pc <= pc + 1'b1;
                    end
                end
                HALT:    Valid <= 1'b0;
                default: state <= BOOT;
            endcase
        end
    end

endmodule

// File: tb/tb_fetch_sequencer.sv
// Scoreboard bench for fetch_sequencer: directed per-cycle vectors queue expected
// output snapshots, a monitor pops and compares them on the falling clock edge.
module tb_fetch_sequencer;

    logic        clk;
    logic        reset_n;
    logic [7:0]  address;
    logic [31:0] instruction_in;
    logic        stall;
    logic        branch_taken;
    logic [7:0]  branch_target;
    logic [31:0] instruction_out;
    logic [7:0]  pc_out;
    logic        valid;
    logic        halted;
    logic [15:0] fetch_count;

    logic [31:0] mem [256];

    typedef struct {
        int          tag;
        logic [7:0]  addr;
        logic [31:0] instr;
        logic [7:0]  pc;
        logic        v;
        logic        h;
        logic [15:0] cnt;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_pass   = 0;
    int   tag_ctr  = 0;
    event chk_ev;

    fetch_sequencer #(
        .ADDR_WIDTH  (8),
        .INSTR_WIDTH (32),
        .RESET_PC    (8'd0),
        .HALT_OPCODE (32'hFFFF_FFFF)
    ) dut (
        .Clk            (clk),
        .Reset_n        (reset_n),
        .Address        (address),
        .InstructionIn  (instruction_in),
        .Stall          (stall),
        .BranchTaken    (branch_taken),
        .BranchTarget   (branch_target),
        .InstructionOut (instruction_out),
        .PCOut          (pc_out),
        .Valid          (valid),
        .Halted         (halted),
        .FetchCount     (fetch_count)
    );

    assign instruction_in = mem[address];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = i;
        mem[23] = 32'hFFFF_FFFF;
    end

    task automatic check(input string name, input int tag, input logic [31:0] got, input logic [31:0] want);
        n_checks++;
        if (got === want) n_pass++;
        else $display("FAIL %s @vec%0d: got %h expected %h", name, tag, got, want);
    endtask

    // Monitor: compares every queued snapshot against the live outputs.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk or chk_ev);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check("address", e.tag, {24'd0, address},     {24'd0, e.addr});
                check("instr",   e.tag, instruction_out,      e.instr);
                check("pcout",   e.tag, {24'd0, pc_out},      {24'd0, e.pc});
                check("valid",   e.tag, {31'd0, valid},       {31'd0, e.v});
                check("halted",  e.tag, {31'd0, halted},      {31'd0, e.h});
                check("count",   e.tag, {16'd0, fetch_count}, {16'd0, e.cnt});
            end
        end
    end

    task automatic push(input logic [7:0] ea, input logic [31:0] ei, input logic [7:0] ep,
                        input logic ev, input logic eh, input logic [15:0] ec);
        exp_t e;
        e.tag = tag_ctr; e.addr = ea; e.instr = ei; e.pc = ep; e.v = ev; e.h = eh; e.cnt = ec;
        tag_ctr++;
        exp_q.push_back(e);
    endtask

    // Drive inputs for one edge, then queue the state expected after that edge.
    task automatic step(input logic st, input logic br, input logic [7:0] tgt,
                        input logic [7:0] ea, input logic [31:0] ei, input logic [7:0] ep,
                        input logic ev, input logic eh, input logic [15:0] ec);
        stall = st; branch_taken = br; branch_target = tgt;
        @(posedge clk);
        #1;
        push(ea, ei, ep, ev, eh, ec);
    endtask

    // Asserts reset between edges and checks the cleared outputs before any edge.
    task automatic do_reset();
        @(negedge clk);
        #1 reset_n = 1'b0;
        #1 push(8'd0, 32'd0, 8'd0, 1'b0, 1'b0, 16'd0);
        -> chk_ev;
        @(posedge clk);
        #1 reset_n = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1, "timeout");
    end

    initial begin
        reset_n = 1'b0; stall = 1'b0; branch_taken = 1'b0; branch_target = 8'd0;
        do_reset();
        //    st br tgt   addr  instr         pc    v  h  cnt
        step(0, 0, 0,    0,    32'd0,        0,    0, 0, 0);   // BOOT bubble
        step(0, 0, 0,    1,    32'd0,        0,    1, 0, 1);
        step(0, 0, 0,    2,    32'd1,        1,    1, 0, 2);
        step(0, 0, 0,    3,    32'd2,        2,    1, 0, 3);
        step(0, 0, 0,    4,    32'd3,        3,    1, 0, 4);
        step(0, 0, 0,    5,    32'd4,        4,    1, 0, 5);
        step(0, 0, 0,    6,    32'd5,        5,    1, 0, 6);
        step(1, 0, 0,    6,    32'd5,        5,    1, 0, 6);   // stall x3
        step(1, 0, 0,    6,    32'd5,        5,    1, 0, 6);
        step(1, 0, 0,    6,    32'd5,        5,    1, 0, 6);
        step(0, 0, 0,    7,    32'd6,        6,    1, 0, 7);
        step(0, 0, 0,    8,    32'd7,        7,    1, 0, 8);
        step(0, 0, 0,    9,    32'd8,        8,    1, 0, 9);
        step(1, 1, 20,   20,   32'd0,        8,    0, 0, 9);   // branch beats stall
        step(0, 0, 0,    21,   32'd20,       20,   1, 0, 10);
        step(0, 0, 0,    22,   32'd21,       21,   1, 0, 11);
        step(0, 0, 0,    23,   32'd22,       22,   1, 0, 12);
        step(0, 0, 0,    23,   32'hFFFFFFFF, 23,   1, 1, 13);  // halt word latched
        step(1, 0, 0,    23,   32'hFFFFFFFF, 23,   1, 1, 13);  // stalled in HALT
        step(0, 0, 0,    23,   32'hFFFFFFFF, 23,   0, 1, 13);
        step(0, 0, 0,    23,   32'hFFFFFFFF, 23,   0, 1, 13);
        step(0, 1, 254,  254,  32'd0,        23,   0, 0, 13);  // leave HALT by branch
        step(0, 0, 0,    255,  32'd254,      254,  1, 0, 14);
        step(0, 0, 0,    0,    32'd255,      255,  1, 0, 15);
        step(0, 0, 0,    1,    32'd0,        0,    1, 0, 16);  // wrap
        step(0, 0, 0,    2,    32'd1,        1,    1, 0, 17);
        step(0, 1, 40,   40,   32'd0,        1,    0, 0, 17);
        step(1, 0, 0,    40,   32'd0,        1,    0, 0, 17);
        stall = 1'b1;
        do_reset();                                              // mid-stall reset
        stall = 1'b0;
        step(0, 0, 0,    0,    32'd0,        0,    0, 0, 0);
        step(0, 0, 0,    1,    32'd0,        0,    1, 0, 1);
        step(0, 0, 0,    2,    32'd1,        1,    1, 0, 2);
        step(0, 1, 20,   20,   32'd0,        1,    0, 0, 2);
        step(0, 0, 0,    21,   32'd20,       20,   1, 0, 3);
        step(0, 0, 0,    22,   32'd21,       21,   1, 0, 4);
        step(0, 0, 0,    23,   32'd22,       22,   1, 0, 5);
        step(0, 0, 0,    23,   32'hFFFFFFFF, 23,   1, 1, 6);
        step(0, 0, 0,    23,   32'hFFFFFFFF, 23,   0, 1, 6);
        step(0, 1, 0,    0,    32'd0,        23,   0, 0, 6);
        step(0, 0, 0,    1,    32'd0,        0,    1, 0, 7);
        step(0, 0, 0,    2,    32'd1,        1,    1, 0, 8);

        for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(negedge clk);
        #1;
        if (exp_q.size() > 0) begin
            n_checks += exp_q.size();
            $display("FAIL drain: got %0d pending expected 0", exp_q.size());
        end
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
